pmem_loader: RTL
================

PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 10, maximum instruction words per frame (1..256).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin receiving a frame.
REQ-005 SHALL have port in_valid  input  1  source holds a valid byte on in_data.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port in_data  input  8  byte stream from source.
REQ-008 SHALL have port pmem_le  output  1  program-memory load enable.
REQ-009 SHALL have port pmem_la  output  8  program-memory load address.
REQ-010 SHALL have port pmem_li  output  12  program-memory load instruction.
REQ-011 SHALL have port load_done  output  1  frame loaded, checksum good.
REQ-012 SHALL have port load_err  output  1  frame rejected.
REQ-013 SHALL have port busy  output  1  frame in progress.

Function
REQ-014 SHALL consume a byte only in a cycle where in_valid and in_ready are both 1; in_valid with in_ready=0 consumes nothing.
REQ-015 SHALL implement states IDLE, COUNT, LO, HI, WRITE, CSUM, DONE, ERR.
REQ-016 SHALL, in IDLE/DONE/ERR on start=1, clear checksum, address and word counter, clear load_done/load_err, go to COUNT; start SHALL be ignored in all other states.
REQ-017 SHALL in COUNT accept word count N; N=0 or N>PROG_DEPTH -> ERR, else store N, add to checksum, -> LO.
REQ-018 SHALL in LO accept low byte (instruction bits 7:0), add to checksum, -> HI.
REQ-019 SHALL in HI accept high byte; bits 7:4 nonzero -> ERR with no write; else add to checksum, form {hi[3:0],lo}, -> WRITE.
REQ-020 SHALL in WRITE hold in_ready=0, drive pmem_le=1 for exactly one cycle with pmem_la=current address, pmem_li=assembled word; then address+1, words+1; words==N -> CSUM, else LO.
REQ-021 SHALL hold pmem_la and pmem_li at last written values when pmem_le=0.
REQ-022 SHALL compute checksum as 8-bit sum modulo 256 of N and every data byte, excluding the checksum byte.
REQ-023 SHALL in CSUM accept one byte; equal to checksum -> DONE, else ERR.
REQ-024 SHALL hold load_done=1 in DONE and load_err=1 in ERR until next start or rst; never both 1.
REQ-025 SHALL drive in_ready=1 only in COUNT, LO, HI, CSUM; busy=1 in COUNT, LO, HI, WRITE, CSUM.
REQ-026 SHALL NOT undo words already written when a frame ends in ERR.
REQ-027 SHALL give address sequence 0..N-1 each frame, never wrapping within a frame.

Reset
REQ-028 SHALL on rst=1 enter IDLE and drive in_ready, pmem_le, pmem_la, pmem_li, load_done, load_err, busy all 0 on the next cycle.
REQ-029 SHALL on rst mid-frame abort with no further pmem_le pulse; rst has priority over start and in_valid.

Verification
REQ-030 SHALL pass: start, bytes 02,34,01,AB,0C then EE -> le pulses LA=0 LI=0x134, LA=1 LI=0xCAB, load_done=1, load_err=0.
REQ-031 SHALL pass: same frame with checksum EF -> both le pulses occur, then load_err=1, load_done=0.
REQ-032 SHALL pass: N=00 and N=0B (PROG_DEPTH=10) -> load_err=1 right after count byte, no le pulse.
REQ-033 SHALL pass: high byte 1C -> load_err=1, no le for that word, in_ready=0 after.
REQ-034 SHALL pass: random in_valid gaps and in_valid high during WRITE -> identical writes to REQ-030, no byte lost or duplicated.
REQ-035 SHALL pass: rst after first word -> all outputs 0 next cycle; new N=10 frame writes LA 0..9 then load_done=1.

Source files
------------

// File: rtl/pmem_loader.sv
// Program-memory loader: receives a counted frame of 12-bit instruction words
// as byte pairs over a valid/ready stream, writes them out, and verifies a trailing checksum.
module pmem_loader #(
  parameter int PROG_DEPTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        pmem_le,
  output logic [7:0]  pmem_la,
  output logic [11:0] pmem_li,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  csum;
  logic [7:0]  lo_byte;
  logic [8:0]  cnt;
  logic [8:0]  n_words;
  logic        take;
  logic [8:0]  cnt_inc;

  assign take    = in_valid & in_ready;
  assign cnt_inc = cnt + 9'd1;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    pmem_le   = 1'b0;
    load_done = (state == S_DONE);
    load_err  = (state == S_ERR);
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx = S_COUNT;
      end
      S_COUNT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take) begin
          if (in_data == 8'd0 || int'(in_data) > PROG_DEPTH) state_nx = S_ERR;
          else                                                  state_nx = S_LO;
        end
      end
      S_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take) state_nx = S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take) begin
          if (in_data[7:4] != 4'd0) state_nx = S_ERR;
          else                      state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        busy    = 1'b1;
        pmem_le = 1'b1;
        if (cnt_inc == n_words) state_nx = S_CSUM;
        else                    state_nx = S_LO;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take) begin
          if (in_data == csum) state_nx = S_DONE;
          else                 state_nx = S_ERR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Load address/word are latched on the high byte so they stay at the last write afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      csum    <= 8'd0;
      cnt     <= 9'd0;
      n_words <= 9'd0;
      lo_byte <= 8'd0;
      pmem_la <= 8'd0;
      pmem_li <= 12'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            csum <= 8'd0;
            cnt  <= 9'd0;
          end
        end
        S_COUNT: begin
          if (take) begin
            n_words <= {1'b0, in_data};
            csum    <= csum + in_data;
          end
        end
        S_LO: begin
          if (take) begin
            lo_byte <= in_data;
            csum    <= csum + in_data;
          end
        end
        S_HI: begin
          if (take && in_data[7:4] == 4'd0) begin
            csum    <= csum + in_data;
            pmem_la <= cnt[7:0];
            pmem_li <= {in_data[3:0], lo_byte};
          end
        end
        S_WRITE: cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

endmodule
